led_mem_arbiter: RTL and testbench
==================================

# led_mem_arbiter

Arbitrated owner of the LED state register. Takes write requests from the UART receive path (command bytes) and the key driver (single-bit updates to the key LED), queues one request per source, and serialises them into the register with round-robin priority. Sits between the UART/key drivers and the LED port driver, replacing a direct memory write path; `out_mem` feeds the LED driver and the key driver's feedback input.

## Interface

- `LED_W`, default 6: width of the LED state register.
- `KEY_BIT`, default 5: register bit owned by key requests.
- `RST_VAL`, default 6'b000000: register value after reset.

- `in_clk`  in  1  system clock; all logic on its rising edge.
- `in_rst`  in  1  reset; synchronous, active-high.
- `in_uart`  in  8  UART command byte; valid only when `in_uart_en`=1.
- `in_uart_en`  in  1  one-cycle strobe; `in_uart` is valid.
- `in_key`  in  1  new value for bit `KEY_BIT`; valid only when `in_key_en`=1.
- `in_key_en`  in  1  one-cycle strobe; `in_key` is valid.
- `out_mem`  out  LED_W  LED state register.
- `out_wr_src`  out  2  source of the last commit: 00 none, 01 UART, 10 key.
- `out_uart_ack`  out  1  one-cycle pulse when a UART request commits.
- `out_key_ack`  out  1  one-cycle pulse when a key request commits.
- `out_ovf`  out  1  sticky; a pending request was overwritten before it committed.

## Operation

- UART byte decode: `op`=byte[7:6], `arg`=byte[5:0].
  - 00 LOAD: `mem`=arg.
  - 01 SET: `mem`|=arg.
  - 10 CLR: `mem`&=~arg.
  - 11 TOG: `mem`^=arg.
- Key request: `mem[KEY_BIT]`=`in_key`; all other bits are unchanged.
- Each source has one pending slot: a valid flag plus payload (8 bits for UART, 1 bit for key).
- A strobe loads that source's slot at the next edge.
- A strobe into a slot that is already valid and not granted this cycle overwrites the payload (newest wins) and sets `out_ovf`.
- `out_ovf` clears only on reset.
- Arbiter, evaluated combinationally on the slot flags each cycle:
  - Exactly one slot valid: grant it.
  - Both valid: grant the source not granted last (`last_grant` pointer).
  - Neither valid: no grant.
- Commit at the edge ending a grant cycle:
  - Update `out_mem` per the decode above.
  - Clear the granted slot's valid flag.
  - Update `last_grant` and `out_wr_src`.
  - Pulse the matching ack for one cycle.
- A strobe arriving in the same cycle its own slot is granted: the old payload commits, and the new payload is stored with valid kept at 1. No overflow is flagged.
- Both strobes in the same cycle: both slots load. The next cycle grants per `last_grant`, and the cycle after grants the other source.

## Timing

- Reset values:
  - `out_mem`=RST_VAL, `out_wr_src`=00.
  - Both acks 0, `out_ovf` 0.
  - Both slots empty.
  - `last_grant`=key, so UART wins the first tie.
- Reset asserted mid-operation discards pending slots. No commit happens in a reset cycle.
- Latency:
  - Strobe in cycle N → slot valid in N+1 → new `out_mem` and ack visible in N+2 (uncontended).
  - Contended: loser commits one cycle after the winner.
- Throughput: at most one commit per cycle.
- Worst-case wait: 1 extra cycle per request.
- No back-pressure to requesters. Overflow is detected and flagged, never stalled.

## Structure

- Package `led_mem_pkg` holds:
  - `typedef enum logic [1:0] {OP_LOAD, OP_SET, OP_CLR, OP_TOG} uart_op_t`.
  - `typedef enum logic [1:0] {SRC_NONE, SRC_UART, SRC_KEY} wr_src_t`.
  - Default `LED_W` and `KEY_BIT` constants.
- One sub-module, `req_slot`, parameterised by payload width. It contains the valid flag, the payload register, and overwrite-with-grant handling, and it generates the overflow event. It is instantiated once per source.
- The arbiter, decode and register stay in the top module.

## Test plan

- Reset, then UART 0x15 (LOAD) → `out_mem`=6'h15 two cycles after the strobe; `out_uart_ack` pulses once; `out_wr_src`=01.
- From `mem`=6'h15: UART 0x4A (SET 0x0A) → 6'h1F; 0x83 (CLR 0x03) → 6'h1C; 0xFF (TOG 0x3F) → 6'h23.
- From `mem`=6'h00: key strobe with `in_key`=1 → `mem`=6'h20, `out_key_ack` pulses, `out_wr_src`=10; then `in_key`=0 → 6'h00.
- Simultaneous UART 0x3F and key=0 strobes after reset → UART commits first (`mem`=6'h3F), then key (`mem`=6'h1F); repeat the same pair → key wins the tie this time.
- Two UART strobes 0x01 then 0x02 on consecutive cycles → a commit for each and `out_ovf` stays 0. Then hold a key request pending, issue two UART strobes 0x05 and 0x06 in back-to-back cycles while the key slot is granted → `out_ovf`=1 and the final UART commit is 6'h06.
- Assert `in_rst` for one cycle while both slots are pending → `out_mem`=0, no acks, and no commits afterwards.

Source files
------------

// File: rtl/led_mem_pkg.sv
// Shared types and default sizes for the LED state register arbiter.
// Contents:
//   uart_op_t  - operation field (bits [7:6]) of a UART command byte
//   wr_src_t   - which requester performed the most recent register commit
//   defaults for the register width, the key-owned bit and the command width
package led_mem_pkg;

  localparam int LED_W_DEF   = 6;
  localparam int KEY_BIT_DEF = 5;
  localparam int UART_W      = 8;

  typedef enum logic [1:0] {OP_LOAD, OP_SET, OP_CLR, OP_TOG} uart_op_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_UART, SRC_KEY} wr_src_t;

endpackage

// File: rtl/led_mem_arbiter_req_slot.sv
// req_slot: a single-entry pending-request holder for one requester.
// A strobe loads the payload and marks the slot valid. A grant empties the
// slot at the same edge unless a fresh strobe arrives in that cycle. In that
// case the granted (old) payload has already been consumed, so the new one
// simply takes its place.
// Ports:
//   in_clk, in_rst  clock and synchronous active-high reset
//   in_strobe       one-cycle request strobe, in_data valid
//   in_data         request payload (W bits)
//   in_grant        arbiter is committing this slot's payload this cycle
//   out_valid       slot holds a pending request
//   out_data        pending payload
//   out_ovf_evt     this cycle's strobe overwrites an uncommitted payload
module req_slot #(
  parameter int W = 8
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_strobe,
  input  logic [W-1:0] in_data,
  input  logic         in_grant,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_ovf_evt
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Losing a payload only counts when it was never committed: a strobe in the
  // grant cycle replaces a payload that is being written out at this edge.
  assign out_ovf_evt = in_strobe & valid_q & ~in_grant;

  always_comb begin
    // NOTE: every always_comb output is given a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (in_grant) valid_d = 1'b0;
    // Newest request wins, and it also wins over the grant's clear.
    if (in_strobe) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge in_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (in_rst) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too even though valid gates it; this keeps X
      // out of the decode logic that reads it.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/led_mem_arbiter.sv
// led_mem_arbiter: owner of the LED state register.
// The UART path (command bytes) and the key driver (single-bit updates) each
// get one pending slot. A round-robin arbiter commits at most one request per
// cycle into the register.
// Ports:
//   in_clk, in_rst     clock and synchronous active-high reset
//   in_uart/_en        UART command byte and its one-cycle strobe
//   in_key/_en         new value for bit KEY_BIT and its one-cycle strobe
//   out_mem            LED state register
//   out_wr_src         source of the last commit (00 none, 01 UART, 10 key)
//   out_uart_ack       one-cycle pulse after a UART commit
//   out_key_ack        one-cycle pulse after a key commit
//   out_ovf            sticky: a pending request was overwritten uncommitted
module led_mem_arbiter
  import led_mem_pkg::*;
#(
  parameter int               LED_W   = LED_W_DEF,
  parameter int               KEY_BIT = KEY_BIT_DEF,
  parameter logic [LED_W-1:0] RST_VAL = '0
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [UART_W-1:0] in_uart,
  input  logic              in_uart_en,
  input  logic              in_key,
  input  logic              in_key_en,
  output logic [LED_W-1:0]  out_mem,
  output logic [1:0]        out_wr_src,
  output logic              out_uart_ack,
  output logic              out_key_ack,
  output logic              out_ovf
);

  logic              uart_valid, key_valid;
  logic [UART_W-1:0] uart_data;
  logic [0:0]        key_data;
  logic              uart_ovf_evt, key_ovf_evt;
  logic              grant_uart, grant_key;
  uart_op_t          uart_op;
  logic [LED_W-1:0]  uart_arg;

  logic [LED_W-1:0]  mem_q, mem_d;
  wr_src_t           wr_src_q, wr_src_d;
  wr_src_t           last_grant_q, last_grant_d;
  logic              uart_ack_q, uart_ack_d;
  logic              key_ack_q, key_ack_d;
  logic              ovf_q, ovf_d;

  req_slot #(.W(UART_W)) u_uart_slot (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_strobe  (in_uart_en),
    .in_data    (in_uart),
    .in_grant   (grant_uart),
    .out_valid  (uart_valid),
    .out_data   (uart_data),
    .out_ovf_evt(uart_ovf_evt)
  );

  req_slot #(.W(1)) u_key_slot (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_strobe  (in_key_en),
    .in_data    (in_key),
    .in_grant   (grant_key),
    .out_valid  (key_valid),
    .out_data   (key_data),
    .out_ovf_evt(key_ovf_evt)
  );

  // A lone request always wins; on a tie the source not served last goes.
  // last_grant resets to SRC_KEY so UART wins the first tie.
  assign grant_uart = uart_valid & (~key_valid | (last_grant_q == SRC_KEY));
  assign grant_key  = key_valid  & (~uart_valid | (last_grant_q == SRC_UART));

  assign uart_op  = uart_op_t'(uart_data[7:6]);
  assign uart_arg = LED_W'(uart_data[5:0]);

  always_comb begin
    mem_d        = mem_q;
    wr_src_d     = wr_src_q;
    last_grant_d = last_grant_q;
    uart_ack_d   = 1'b0;
    key_ack_d    = 1'b0;
    ovf_d        = ovf_q | uart_ovf_evt | key_ovf_evt;

    if (grant_uart) begin
      unique case (uart_op)
        OP_LOAD: mem_d = uart_arg;
        OP_SET:  mem_d = mem_q | uart_arg;
        OP_CLR:  mem_d = mem_q & ~uart_arg;
        OP_TOG:  mem_d = mem_q ^ uart_arg;
        default: mem_d = mem_q;
      endcase
      wr_src_d     = SRC_UART;
      last_grant_d = SRC_UART;
      uart_ack_d   = 1'b1;
    end else if (grant_key) begin
      mem_d[KEY_BIT] = key_data[0];
      wr_src_d       = SRC_KEY;
      last_grant_d   = SRC_KEY;
      key_ack_d      = 1'b1;
    end
  end

  // Reset has priority, so a grant computed in a reset cycle never commits.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      mem_q        <= RST_VAL;
      wr_src_q     <= SRC_NONE;
      last_grant_q <= SRC_KEY;
      uart_ack_q   <= 1'b0;
      key_ack_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_src_q     <= wr_src_d;
      last_grant_q <= last_grant_d;
      uart_ack_q   <= uart_ack_d;
      key_ack_q    <= key_ack_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_mem      = mem_q;
  assign out_wr_src   = wr_src_q;
  assign out_uart_ack = uart_ack_q;
  assign out_key_ack  = key_ack_q;
  assign out_ovf      = ovf_q;

endmodule

// File: tb/tb_led_mem_arbiter.sv
// Testbench for led_mem_arbiter: a table of hand-derived vectors for the
// directed scenarios, then randomized traffic compared against a request-level
// reference model.
module tb_led_mem_arbiter;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic [7:0] in_uart = '0;
  logic       in_uart_en = 1'b0;
  logic       in_key = 1'b0;
  logic       in_key_en = 1'b0;
  logic [5:0] out_mem;
  logic [1:0] out_wr_src;
  logic       out_uart_ack;
  logic       out_key_ack;
  logic       out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  led_mem_arbiter dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_uart     (in_uart),
    .in_uart_en  (in_uart_en),
    .in_key      (in_key),
    .in_key_en   (in_key_en),
    .out_mem     (out_mem),
    .out_wr_src  (out_wr_src),
    .out_uart_ack(out_uart_ack),
    .out_key_ack (out_key_ack),
    .out_ovf     (out_ovf)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    bit       rst;
    bit       uart_en;
    bit [7:0] uart;
    bit       key_en;
    bit       key;
    bit [5:0] mem;
    bit [1:0] src;
    bit       uack;
    bit       kack;
    bit       ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit ue, bit [7:0] u, bit ke, bit k,
                              bit [5:0] m, bit [1:0] s, bit ua, bit ka, bit o);
    vec_t v;
    v.rst = r; v.uart_en = ue; v.uart = u; v.key_en = ke; v.key = k;
    v.mem = m; v.src = s; v.uack = ua; v.kack = ka; v.ovf = o;
    return v;
  endfunction

  // Reference model: each source is a one-deep mailbox (index 0 UART, 1 key).
  bit       m_pend[2];
  int       m_data[2];
  int       m_last;
  int       m_mem;
  int       m_src;
  bit       m_ack[2];
  bit       m_ovf;

  function automatic int apply_uart(int mem, int b);
    int op;
    int arg;
    op  = b / 64;
    arg = b % 64;
    case (op)
      0:       return arg;
      1:       return mem | arg;
      2:       return mem & (63 - arg);
      default: return mem ^ arg;
    endcase
  endfunction

  task automatic model_step(bit r, bit ue, int u, bit ke, int k);
    int  g;
    bit  strobe[2];
    int  nd[2];
    strobe[0] = ue; strobe[1] = ke;
    nd[0] = u; nd[1] = k;
    m_ack[0] = 0; m_ack[1] = 0;
    if (r) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_last = 1; m_mem = 0; m_src = 0; m_ovf = 0;
      return;
    end
    g = -1;
    if (m_pend[0] && m_pend[1]) g = (m_last == 1) ? 0 : 1;
    else if (m_pend[0])         g = 0;
    else if (m_pend[1])         g = 1;
    for (int s = 0; s < 2; s++)
      if (strobe[s] && m_pend[s] && g != s) m_ovf = 1;
    if (g == 0) m_mem = apply_uart(m_mem, m_data[0]);
    if (g == 1) m_mem = m_data[1] ? (m_mem | 32) : (m_mem & 31);
    if (g >= 0) begin
      m_pend[g] = 0;
      m_last    = g;
      m_src     = g + 1;
      m_ack[g]  = 1;
    end
    for (int s = 0; s < 2; s++)
      if (strobe[s]) begin
        m_pend[s] = 1;
        m_data[s] = nd[s];
      end
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, let the edge happen, step the model, and
  // return #1 after the edge so outputs can be sampled.
  task automatic cycle(bit r, bit ue, bit [7:0] u, bit ke, bit k);
    in_rst = r; in_uart_en = ue; in_uart = u; in_key_en = ke; in_key = k;
    @(posedge in_clk);
    model_step(r, ue, int'(u), ke, int'(k));
    #1;
    in_rst = 0; in_uart_en = 0; in_key_en = 0;
  endtask

  initial begin
    // Reset and the four UART ops.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h15, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h15, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h15, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h4A, 0, 0, 6'h15, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h1F, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h83, 0, 0, 6'h1F, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h1C, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 6'h1C, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h23, 2'd1, 1, 0, 0));
    // LOAD 0, then key set/clear of bit 5.
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 6'h23, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h00, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 6'h00, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h20, 2'd2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 6'h20, 2'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h00, 2'd2, 0, 1, 0));
    // Tie after reset: UART first. The pair repeated while UART is being
    // granted refills UART, overwrites the waiting key, and key wins the tie.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h3F, 1, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h3F, 1, 0, 6'h3F, 2'd1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h1F, 2'd2, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h3F, 2'd1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h3F, 2'd1, 0, 0, 1));
    // Back-to-back UART strobes: second lands in the grant cycle, no overflow.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h02, 0, 0, 6'h01, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h02, 2'd1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h02, 2'd1, 0, 0, 0));
    // Key pending and granted while UART 05 waits: UART 06 overwrites it.
    tbl.push_back(mk(0, 1, 8'h05, 1, 1, 6'h02, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h06, 0, 0, 6'h22, 2'd2, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h06, 2'd1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h06, 2'd1, 0, 0, 1));
    // Reset with both slots pending discards them.
    tbl.push_back(mk(0, 1, 8'h3F, 1, 1, 6'h06, 2'd1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 6'h00, 2'd0, 0, 0, 0));

    @(negedge in_clk);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].uart_en, tbl[i].uart, tbl[i].key_en, tbl[i].key);
      check($sformatf("vec%0d mem", i),  int'(out_mem),      int'(tbl[i].mem));
      check($sformatf("vec%0d src", i),  int'(out_wr_src),   int'(tbl[i].src));
      check($sformatf("vec%0d uack", i), int'(out_uart_ack), int'(tbl[i].uack));
      check($sformatf("vec%0d kack", i), int'(out_key_ack),  int'(tbl[i].kack));
      check($sformatf("vec%0d ovf", i),  int'(out_ovf),      int'(tbl[i].ovf));
    end

    // Randomized traffic against the model.
    cycle(1, 0, 8'h00, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit       r, ue, ke, k;
      bit [7:0] u;
      r  = ($urandom_range(0, 99) < 2);
      ue = ($urandom_range(0, 99) < 40);
      ke = ($urandom_range(0, 99) < 40);
      u  = 8'($urandom);
      k  = 1'($urandom);
      cycle(r, ue, u, ke, k);
      check($sformatf("rnd%0d mem", n),  int'(out_mem),      m_mem);
      check($sformatf("rnd%0d src", n),  int'(out_wr_src),   m_src);
      check($sformatf("rnd%0d uack", n), int'(out_uart_ack), int'(m_ack[0]));
      check($sformatf("rnd%0d kack", n), int'(out_key_ack),  int'(m_ack[1]));
      check($sformatf("rnd%0d ovf", n),  int'(out_ovf),      int'(m_ovf));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
